// File: rtl/dmem_ctrl.sv
// Data-memory access controller: steers CPU loads/stores onto a byte-lane RAM,
// formats the registered read word, and arbitrates a low-priority host word port.
module dmem_ctrl #(
    parameter int DRWIDTH = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ma_req,
    input  logic               ma_we,
    input  logic [1:0]         ma_size,
    input  logic               ma_unsigned,
    input  logic [31:0]        ma_adr,
    input  logic [31:0]        ma_wdata,
    output logic [31:0]        ld_data,
    output logic               ld_valid,
    output logic               misalign,
    input  logic               host_req,
    input  logic               host_we,
    input  logic [DRWIDTH-1:0] host_adr,
    input  logic [31:0]        host_wdata,
    output logic               host_ack,
    output logic [31:0]        host_rdata,
    output logic [DRWIDTH-1:0] ram_radr,
    output logic [DRWIDTH-1:0] ram_wadr,
    output logic [31:0]        ram_wdata,
    output logic [3:0]         ram_wen,
    input  logic [31:0]        ram_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HBUSY = 2'd1,
        HDONE = 2'd2
    } host_state_e;

    host_state_e state_q, state_d;
    logic        host_grant;
    logic        host_we_q;
    logic [31:0] host_rdata_q;

    logic        ld_pend_q;
    logic [1:0]  ld_off_q;
    logic [1:0]  ld_size_q;
    logic        ld_uns_q;
    logic        misalign_q;

    logic        ma_misaligned;
    logic [3:0]  cpu_wen;
    logic [31:0] cpu_wdata;
    logic [15:0] ld_half;
    logic [7:0]  ld_byte;

    // Upper CPU address bits fall outside the RAM and are deliberately dropped.
    logic unused_adr_bits;
    assign unused_adr_bits = ^ma_adr[31:DRWIDTH+2];

    assign ma_misaligned = (ma_size == 2'b01) ? ma_adr[0]
                         : ma_size[1]         ? (ma_adr[1:0] != 2'b00)
                         :                      1'b0;

    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        host_grant = 1'b0;
        case (state_q)
            IDLE: begin
                if (host_req && !ma_req) begin
                    host_grant = 1'b1;
                    state_d    = HBUSY;
                end
            end
            HBUSY:   state_d = HDONE;
            HDONE:   if (!host_req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cpu_wdata = ma_wdata;
        cpu_wen   = 4'b1111;
        case (ma_size)
            2'b00: begin
                cpu_wdata = {4{ma_wdata[7:0]}};
                cpu_wen   = 4'b0001 << ma_adr[1:0];
            end
            2'b01: begin
                cpu_wdata = {2{ma_wdata[15:0]}};
                cpu_wen   = ma_adr[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    assign ram_radr = ma_req ? ma_adr[DRWIDTH+1:2] : host_adr;
    assign ram_wadr = ram_radr;

    always_comb begin
        ram_wdata = host_wdata;
        ram_wen   = 4'b0000;
        if (ma_req) begin
            ram_wdata = cpu_wdata;
            if (ma_we && !ma_misaligned) ram_wen = cpu_wen;
        end else if (host_grant && host_we) begin
            ram_wen = 4'b1111;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            host_we_q    <= 1'b0;
            host_rdata_q <= 32'h0;
            ld_pend_q    <= 1'b0;
            ld_off_q     <= 2'b00;
            ld_size_q    <= 2'b00;
            ld_uns_q     <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ld_pend_q  <= ma_req && !ma_we && !ma_misaligned;
            ld_off_q   <= ma_adr[1:0];
            ld_size_q  <= ma_size;
            ld_uns_q   <= ma_unsigned;
            misalign_q <= ma_req && ma_misaligned;
            if (host_grant) host_we_q <= host_we;
            if (state_q == HBUSY && !host_we_q) host_rdata_q <= ram_rdata;
        end
    end

    // The read word arrives in HBUSY; pass it straight through so it is valid
    // in the same cycle host_ack rises, then hold the captured copy.
    assign host_ack   = (state_q == HBUSY) || (state_q == HDONE);
    assign host_rdata = (state_q == HBUSY && !host_we_q) ? ram_rdata : host_rdata_q;

    assign ld_byte = ram_rdata[{ld_off_q, 3'b000} +: 8];
    assign ld_half = ld_off_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];

    always_comb begin
        ld_data = 32'h0;
        if (ld_pend_q) begin
            case (ld_size_q)
                2'b00:   ld_data = {{24{!ld_uns_q && ld_byte[7]}}, ld_byte};
                2'b01:   ld_data = {{16{!ld_uns_q && ld_half[15]}}, ld_half};
                default: ld_data = ram_rdata;
            endcase
        end
    end

    assign ld_valid = ld_pend_q;
    assign misalign = misalign_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: directed CPU/host vectors push expectations,
// a negedge monitor pops and compares whenever the DUT presents a result.
module tb_dmem_ctrl;

    localparam int DRWIDTH = 12;

    typedef struct {
        bit          is_mis;
        logic [31:0] data;
    } exp_t;

    logic               clk;
    logic               rst;
    logic               ma_req;
    logic               ma_we;
    logic [1:0]         ma_size;
    logic               ma_unsigned;
    logic [31:0]        ma_adr;
    logic [31:0]        ma_wdata;
    logic [31:0]        ld_data;
    logic               ld_valid;
    logic               misalign;
    logic               host_req;
    logic               host_we;
    logic [DRWIDTH-1:0] host_adr;
    logic [31:0]        host_wdata;
    logic               host_ack;
    logic [31:0]        host_rdata;
    logic [DRWIDTH-1:0] ram_radr;
    logic [DRWIDTH-1:0] ram_wadr;
    logic [31:0]        ram_wdata;
    logic [3:0]         ram_wen;
    logic [31:0]        ram_rdata;

    int total = 0;
    int bad   = 0;

    exp_t        sb_q[$];
    logic [31:0] host_q[$];
    exp_t        e;
    logic        ack_prev = 1'b0;

    logic [31:0] mem [0:(1<<DRWIDTH)-1];

    dmem_ctrl #(.DRWIDTH(DRWIDTH)) dut (
        .clk(clk), .rst(rst),
        .ma_req(ma_req), .ma_we(ma_we), .ma_size(ma_size), .ma_unsigned(ma_unsigned),
        .ma_adr(ma_adr), .ma_wdata(ma_wdata),
        .ld_data(ld_data), .ld_valid(ld_valid), .misalign(misalign),
        .host_req(host_req), .host_we(host_we), .host_adr(host_adr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_rdata(host_rdata),
        .ram_radr(ram_radr), .ram_wadr(ram_wadr), .ram_wdata(ram_wdata),
        .ram_wen(ram_wen), .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-lane RAM model with a one-cycle registered read.
    initial begin
        for (int i = 0; i < (1<<DRWIDTH); i++) mem[i] = 32'h0;
        ram_rdata = 32'h0;
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (ram_wen[i]) mem[ram_wadr][8*i +: 8] <= ram_wdata[8*i +: 8];
        ram_rdata <= mem[ram_radr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Result monitor: load/misalign events and host acknowledge edges.
    always @(negedge clk) begin
        if (!rst) begin
            if (ld_valid || misalign) begin
                check("ld_mis_exclusive", {31'b0, ld_valid & misalign}, 32'h0);
                check("sb_has_entry", {31'b0, sb_q.size() > 0}, 32'h1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("result_kind", {31'b0, misalign}, {31'b0, e.is_mis});
                    if (!e.is_mis) check("ld_data", ld_data, e.data);
                end
            end
            if (host_ack && !ack_prev) begin
                check("host_q_has_entry", {31'b0, host_q.size() > 0}, 32'h1);
                if (host_q.size() > 0) check("host_rdata", host_rdata, host_q.pop_front());
            end
        end
        ack_prev = host_ack;
    end

    task automatic cpu(input string nm, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] adr, input logic [31:0] wd,
                       input logic [3:0] exp_wen, input logic [31:0] exp_wdata,
                       input bit exp_mis, input logic [31:0] exp_ld);
        exp_t x;
        @(posedge clk); #1;
        ma_req = 1'b1; ma_we = we; ma_size = size; ma_unsigned = uns;
        ma_adr = adr; ma_wdata = wd;
        x.is_mis = exp_mis;
        x.data   = exp_ld;
        if (exp_mis || !we) sb_q.push_back(x);
        @(negedge clk);
        check({nm, "_wen"}, {28'b0, ram_wen}, {28'b0, exp_wen});
        check({nm, "_radr"}, {20'b0, ram_radr}, {20'b0, adr[DRWIDTH+1:2]});
        if (exp_wen != 4'b0000) check({nm, "_wdata"}, ram_wdata, exp_wdata);
    endtask

    task automatic cpu_idle();
        @(posedge clk); #1;
        ma_req = 1'b0; ma_we = 1'b0;
    endtask

    task automatic wait_ack(input string nm, input logic lvl);
        int n = 0;
        @(negedge clk);
        while (host_ack !== lvl && n < 10) begin
            @(negedge clk);
            n++;
        end
        check(nm, {31'b0, host_ack}, {31'b0, lvl});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        ma_req = 1'b0; ma_we = 1'b0; ma_size = 2'b00; ma_unsigned = 1'b0;
        ma_adr = 32'h0; ma_wdata = 32'h0;
        host_req = 1'b0; host_we = 1'b0; host_adr = '0; host_wdata = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_ld_data", ld_data, 32'h0);
        check("rst_ld_valid", {31'b0, ld_valid}, 32'h0);
        check("rst_misalign", {31'b0, misalign}, 32'h0);
        check("rst_host_ack", {31'b0, host_ack}, 32'h0);
        check("rst_host_rdata", host_rdata, 32'h0);
        check("rst_wen", {28'b0, ram_wen}, 32'h0);
        @(posedge clk); #1 rst = 1'b0;

        // CPU store/load steering, back-to-back, sign/zero extension, misalignment.
        cpu("sw10",  1, 2'b10, 0, 32'h10, 32'h11223344, 4'hF, 32'h11223344, 0, 32'h0);
        cpu("lw10",  0, 2'b10, 0, 32'h10, 32'h0, 4'h0, 32'h0, 0, 32'h11223344);
        cpu("sb13",  1, 2'b00, 0, 32'h13, 32'h80, 4'h8, 32'h80808080, 0, 32'h0);
        cpu("lb13",  0, 2'b00, 0, 32'h13, 32'h0, 4'h0, 32'h0, 0, 32'hFFFFFF80);
        cpu("lbu13", 0, 2'b00, 1, 32'h13, 32'h0, 4'h0, 32'h0, 0, 32'h00000080);
        cpu("sh22",  1, 2'b01, 0, 32'h22, 32'hBEEF, 4'hC, 32'hBEEFBEEF, 0, 32'h0);
        cpu("lh22",  0, 2'b01, 0, 32'h22, 32'h0, 4'h0, 32'h0, 0, 32'hFFFFBEEF);
        cpu("lhu22", 0, 2'b01, 1, 32'h22, 32'h0, 4'h0, 32'h0, 0, 32'h0000BEEF);
        cpu("lh21",  0, 2'b01, 0, 32'h21, 32'h0, 4'h0, 32'h0, 1, 32'h0);
        cpu("lw10b", 0, 2'b10, 0, 32'h10, 32'h0, 4'h0, 32'h0, 0, 32'h80223344);
        cpu("lb10",  0, 2'b00, 0, 32'h10, 32'h0, 4'h0, 32'h0, 0, 32'h00000044);
        cpu("lh12",  0, 2'b01, 0, 32'h12, 32'h0, 4'h0, 32'h0, 0, 32'hFFFF8022);
        cpu("sw11",  1, 2'b10, 0, 32'h11, 32'hDEADBEEF, 4'h0, 32'h0, 1, 32'h0);
        cpu("lbu11", 0, 2'b00, 1, 32'h11, 32'h0, 4'h0, 32'h0, 0, 32'h00000033);
        cpu("lw_hi", 0, 2'b11, 0, 32'h00010010, 32'h0, 4'h0, 32'h0, 0, 32'h80223344);
        cpu_idle();

        // Host read blocked while the CPU keeps ma_req high.
        cpu("lw20", 0, 2'b10, 0, 32'h20, 32'h0, 4'h0, 32'h0, 0, 32'hBEEF0000);
        host_req = 1'b1; host_we = 1'b0; host_adr = 12'd4;
        host_q.push_back(32'h80223344);
        for (int k = 0; k < 5; k++) begin
            cpu("lw20h", 0, 2'b10, 0, 32'h20, 32'h0, 4'h0, 32'h0, 0, 32'hBEEF0000);
            check("host_blocked", {31'b0, host_ack}, 32'h0);
        end
        cpu_idle();
        @(negedge clk);
        check("grant_ack_low", {31'b0, host_ack}, 32'h0);
        check("grant_radr", {20'b0, ram_radr}, 32'd4);
        check("grant_rd_wen", {28'b0, ram_wen}, 32'h0);
        @(negedge clk);
        check("ack_rise", {31'b0, host_ack}, 32'h1);
        @(posedge clk); #1 host_req = 1'b0;
        @(negedge clk);
        check("ack_hold", {31'b0, host_ack}, 32'h1);
        @(negedge clk);
        check("ack_fall", {31'b0, host_ack}, 32'h0);

        // Host write, then CPU reads it back.
        @(posedge clk); #1;
        host_req = 1'b1; host_we = 1'b1; host_adr = 12'd3; host_wdata = 32'hCAFEBABE;
        host_q.push_back(32'h80223344);
        @(negedge clk);
        check("hw_wen", {28'b0, ram_wen}, 32'hF);
        check("hw_wadr", {20'b0, ram_wadr}, 32'd3);
        check("hw_wdata", ram_wdata, 32'hCAFEBABE);
        wait_ack("hw_ack_up", 1'b1);
        @(posedge clk); #1 host_req = 1'b0; host_we = 1'b0;
        wait_ack("hw_ack_down", 1'b0);
        cpu("lw0c", 0, 2'b10, 0, 32'h0C, 32'h0, 4'h0, 32'h0, 0, 32'hCAFEBABE);
        cpu_idle();

        // Reset while in HDONE with a CPU load in flight.
        @(posedge clk); #1;
        host_req = 1'b1; host_we = 1'b0; host_adr = 12'd8;
        host_q.push_back(32'hBEEF0000);
        wait_ack("hr2_ack_up", 1'b1);
        @(posedge clk); #1;
        ma_req = 1'b1; ma_we = 1'b0; ma_size = 2'b10; ma_adr = 32'h0C;
        @(negedge clk);
        check("hdone_ack", {31'b0, host_ack}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b1; ma_req = 1'b0;
        #1;
        check("mid_rst_ack", {31'b0, host_ack}, 32'h0);
        check("mid_rst_ld_valid", {31'b0, ld_valid}, 32'h0);
        check("mid_rst_ld_data", ld_data, 32'h0);
        check("mid_rst_misalign", {31'b0, misalign}, 32'h0);
        check("mid_rst_host_rdata", host_rdata, 32'h0);
        check("mid_rst_wen", {28'b0, ram_wen}, 32'h0);
        host_q.push_back(32'hBEEF0000);
        @(posedge clk); #1 rst = 1'b0;
        wait_ack("post_rst_ack_up", 1'b1);
        @(posedge clk); #1 host_req = 1'b0;
        wait_ack("post_rst_ack_down", 1'b0);

        repeat (3) @(negedge clk);
        check("sb_empty", sb_q.size(), 32'h0);
        check("host_q_empty", host_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
